// File: rtl/datapath_mc.sv
// Register-file datapath with shifter, ALU, C/status registers and a shift-add multiplier.
// Latency: ALU ops 1 cycle; MUL WIDTH cycles. No backpressure; the controller stalls on busy.
module datapath_mc #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int PCW   = 8,
    localparam int RAW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RAW-1:0]   readnum,
    input  logic [RAW-1:0]   writenum,
    input  logic             write,
    input  logic             loada,
    input  logic             loadb,
    input  logic             loadc,
    input  logic             loads,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       vsel,
    input  logic [1:0]       shift,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] mdata,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [WIDTH-1:0] sximm5,
    input  logic [PCW-1:0]   PC,
    output logic [WIDTH-1:0] C,
    output logic [2:0]       statusout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [2:0]       r_status;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_mul_s;
    logic             r_done;

    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_pc_ext;
    logic [WIDTH-1:0] w_shout;
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_alu;
    logic             w_v;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_mul_req;
    logic             w_start;
    logic             w_finish;
    logic             w_single;

    assign w_pc_ext = WIDTH'(PC);
    assign w_rdata  = r_regs[readnum];

    always_comb begin
        w_wdata = mdata;
        case (vsel)
            2'b00:   w_wdata = mdata;
            2'b01:   w_wdata = sximm8;
            2'b10:   w_wdata = w_pc_ext;
            default: w_wdata = r_c;
        endcase
    end

    // Read-before-write: a same-cycle read of writenum still sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (write) begin
            r_regs[writenum] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (loada) r_a <= w_rdata;
            if (loadb) r_b <= w_rdata;
        end
    end

    always_comb begin
        w_shout = r_b;
        case (shift)
            2'b00:   w_shout = r_b;
            2'b01:   w_shout = {r_b[WIDTH-2:0], 1'b0};
            2'b10:   w_shout = {1'b0, r_b[WIDTH-1:1]};
            default: w_shout = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
        endcase
    end

    assign w_ain = asel ? '0 : r_a;
    assign w_bin = bsel ? sximm5 : w_shout;

    always_comb begin
        w_alu = w_ain + w_bin;
        w_v   = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
        case (ALUop)
            3'b001: begin
                w_alu = w_ain - w_bin;
                w_v   = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            end
            3'b010: begin
                w_alu = w_ain & w_bin;
                w_v   = 1'b0;
            end
            3'b011: begin
                w_alu = ~w_bin;
                w_v   = 1'b0;
            end
            3'b100: w_v = 1'b0;
            default: ;
        endcase
    end

    assign w_mul_req = loadc && (ALUop == 3'b100);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mul_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mul_s  <= 1'b0;
        end else if (w_start) begin
            r_mcand  <= w_ain;
            r_mplier <= w_bin;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH - 1);
            r_mul_s  <= loads;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= w_finish ? '0 : r_cnt - 1'b1;
        end
    end

    // Single-cycle updates only while idle; a MUL opcode never updates C/status directly.
    assign w_single = (r_state == S_IDLE) && (ALUop != 3'b100);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c      <= '0;
            r_status <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_c <= w_acc_nxt;
                if (r_mul_s) r_status <= {1'b0, w_acc_nxt[WIDTH-1], (w_acc_nxt == '0)};
            end else if (w_single) begin
                if (loadc) r_c <= w_alu;
                if (loads) r_status <= {w_v, w_alu[WIDTH-1], (w_alu == '0)};
            end
        end
    end

    assign C         = r_c;
    assign statusout = r_status;
    assign busy      = (r_state == S_MUL);
    assign done      = r_done;

endmodule

// File: doc/datapath_mc.md
# datapath_mc

Parametrised successor of the lab datapath: an N-entry register file, A/B operand registers, a barrel-lite shifter, operand muxes, ALU, and C/status registers. It generalises data width, register count and PC width. It adds a multi-cycle shift-add multiply, with a busy/done handshake, alongside the single-cycle ALU ops. It sits under the CPU controller FSM, which drives every load/select strobe and stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 16, datapath/register width (≥4)
- `NREG`, 8, register-file entries (power of 2, ≥2); `RAW = $clog2(NREG)`
- `PCW`, 8, PC width (≤ WIDTH)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `readnum`, `writenum`  in  RAW  register-file read/write index
- `write`  in  1  register-file write enable
- `loada`, `loadb`, `loadc`, `loads`  in  1  A/B/C/status load enables
- `asel`  in  1  1 = Ain is zero, 0 = Ain is A
- `bsel`  in  1  1 = Bin is sximm5, 0 = Bin is shifter output
- `vsel`  in  2  write-data select: 00 mdata, 01 sximm8, 10 {zero, PC}, 11 C
- `shift`  in  2  00 pass, 01 shift left by 1 (zero fill), 10 logical shift right by 1, 11 arithmetic shift right by 1
- `ALUop`  in  3  000 ADD, 001 SUB, 010 AND, 011 NOT B, 100 MUL (multi-cycle), others behave as ADD
- `mdata`, `sximm8`, `sximm5`  in  WIDTH  external data / sign-extended immediates
- `PC`  in  PCW  program counter, zero-extended to WIDTH
- `C`  out  WIDTH  result register
- `statusout`  out  3  {V, N, Z}
- `busy`  out  1  multiply in progress
- `done`  out  1  one-cycle pulse: multiply result now in C

## Operation
- Register file: synchronous write at clk when `write`. Read is combinational on `readnum`. A read of the same index in the write cycle returns the old value.
- A and B load from the register-file read port. Ain/Bin are muxed per `asel`/`bsel`.
- Single-cycle ops (ALUop ≠ 100): at a clock edge with `loadc`, C ← ALU result (mod 2^WIDTH). At an edge with `loads`, status ← flags.
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB; V = 0 for AND, NOT and MUL.
- FSM states IDLE, MUL:
  - IDLE → MUL on an edge with `loadc` and ALUop = 100. On that edge:
    - Capture Ain as multiplicand and Bin as multiplier.
    - Clear the accumulator and set the counter to WIDTH-1.
    - Latch `loads` as `mul_s`.
    - C and status do not change on this edge.
  - Each edge in MUL:
    - If multiplier[0] = 1, the accumulator adds the multiplicand.
    - Shift the multiplicand left by 1 and the multiplier right by 1, then decrement the counter.
  - Edge in MUL with counter = 0:
    - C ← final low WIDTH bits of the product (unsigned; upper bits discarded).
    - If `mul_s`, status ← {0, N, Z} of that value.
    - done ← 1; next state IDLE.
- While `busy`:
  - `loadc` and `loads` are ignored, including a second MUL request.
  - `loada`, `loadb` and `write` still act.
  - vsel = 11 writes the old C.
  - Changes to ALUop/asel/bsel do not affect the multiply in flight.
- Reset (any time, including mid-multiply):
  - All registers in the file, A, B, C and status go to 0.
  - Accumulator and counter go to 0; state goes to IDLE.
  - `busy` = 0 and `done` = 0.

## Timing
- Reset values: C = 0, statusout = 000, busy = 0, done = 0.
- Single-cycle ops: C/status are valid after the loadc/loads edge (latency 1).
- MUL: start edge E0 sets `busy` = 1.
  - C, status and `done` update at edge E0 + WIDTH; `busy` falls at that same edge.
  - `busy` is therefore high for exactly WIDTH cycles.
  - `done` is high for exactly the one cycle after E0 + WIDTH.
- A new request (MUL or single-cycle) is accepted at edge E0 + WIDTH + 1 or later. A `loadc` sampled at E0 + WIDTH itself is ignored.
- `done` and `busy` are never high simultaneously.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle. Then C = 0, statusout = 000, busy = 0, and a read of every register returns 0.
- ADD: R0 = 3, R1 = 5 via sximm8 writes; load A ← R0 and B ← R1; ADD with loadc and loads. Then C = 8 and statusout = 000.
- SUB overflow: A = 0x8000, B = 1, SUB with loads. Then C = 0x7FFF and statusout = {V = 1, N = 0, Z = 0}. NOT B with B = 0xFFFF and shift = 00 gives C = 0 and Z = 1.
- MUL 7 × 9, WIDTH = 16, loads = 1:
  - busy is high for 16 cycles; C holds its old value until edge E0 + 16, then becomes 63.
  - done pulses for 1 cycle; statusout = 000.
  - A `loadc` issued mid-busy (ALUop = 000) leaves C unchanged.
- MUL truncation: 0x0100 × 0x0100 gives C = 0 and Z = 1. Also run the product 0xFFFF × 0xFFFF and check C = 0x0001.
- Reset at cycle 5 of a multiply: busy drops immediately, C = 0, and done never pulses. A fresh MUL afterwards completes correctly.
